// File: rtl/cpu_pkg.sv
//------------------------------------------------------------------------------
// Module  : cpu_pkg
// Purpose : Shared CPU-wide constants and types for the instruction fetch path.
//           INST_W   - instruction word width
//           NOP_INST - default instruction presented when nothing is queued
//           fetch_state_t - prefetch request FSM encoding
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpu_pkg;

    localparam int INST_W = 32;
    localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/inst_prefetch_queue_if.sv
//------------------------------------------------------------------------------
// Module  : inst_prefetch_queue_if
// Purpose : Bundles the instruction-RAM handshake, the redirect request and the
//           decode-side head/stall signals of the prefetch queue.
//           master - the prefetch queue
//           slave  - the environment (instruction RAM, branch unit, if_id)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface inst_prefetch_queue_if #(
    parameter int DEPTH = 4
) ();
    import cpu_pkg::*;

    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    // Redirect from the branch/jump unit
    logic                redirect;
    logic [31:0]         redirect_addr;
    // Instruction RAM handshake
    logic                iread_ce;
    logic [31:0]         iram_addr;
    logic [INST_W-1:0]   ram_inst;
    logic                irom_fin;
    // Decode side
    logic                stall_if;
    logic                inst_valid;
    logic [INST_W-1:0]   inst;
    logic [31:0]         inst_address;
    logic [31:0]         next_instaddress;
    logic [c_CNT_W-1:0]  count;

    modport master (
        input  redirect, redirect_addr, ram_inst, irom_fin, stall_if,
        output iread_ce, iram_addr, inst_valid, inst, inst_address,
               next_instaddress, count
    );

    modport slave (
        output redirect, redirect_addr, ram_inst, irom_fin, stall_if,
        input  iread_ce, iram_addr, inst_valid, inst, inst_address,
               next_instaddress, count
    );

endinterface

`default_nettype wire

// File: rtl/sync_fifo_flush.sv
//------------------------------------------------------------------------------
// Module  : sync_fifo_flush
// Purpose : Circular-buffer FIFO with synchronous flush, occupancy count and a
//           combinational head read.
// Ports   : clk, rst      - clock, synchronous active-high reset
//           i_flush       - empty the FIFO on the next edge (beats push/pop)
//           i_push/i_wr_data - write one entry
//           i_pop         - retire the head entry
//           o_rd_data     - head entry (valid when !o_empty)
//           o_count       - occupancy, 0..DEPTH
//           o_empty       - no entries held
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sync_fifo_flush #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);
    // A push into a full FIFO is only legal when the head leaves in the
    // same cycle; a pop from an empty FIFO never sees the same-cycle push.
    assign w_do_push = i_push && (!w_full || i_pop);
    assign w_do_pop  = i_pop && !w_empty;

    // Storage needs no reset: entries are only visible through r_count.
    always_ff @(posedge clk) begin
        if (w_do_push && !i_flush) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_count   = r_count;
    assign o_empty   = w_empty;

endmodule

`default_nettype wire

// File: rtl/inst_prefetch_queue.sv
//------------------------------------------------------------------------------
// Module  : inst_prefetch_queue
// Purpose : Instruction-fetch front end. Issues instruction-RAM reads ahead of
//           decode into a DEPTH-entry queue of {pc, inst}, absorbs variable
//           irom_fin latency and flushes on redirect, discarding a read that
//           is already in flight.
// Ports   : clk, rst - clock, synchronous active-high reset
//           bus      - inst_prefetch_queue_if.master:
//                      redirect/redirect_addr  in  : flush and restart fetch
//                      iread_ce/iram_addr      out : RAM read request
//                      ram_inst/irom_fin       in  : RAM read completion
//                      stall_if                in  : hold the head entry
//                      inst_valid/inst/inst_address/next_instaddress out
//                      count                   out : queue occupancy
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module inst_prefetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = cpu_pkg::NOP_INST
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_prefetch_queue_if.master bus
);

    import cpu_pkg::INST_W;
    import cpu_pkg::fetch_state_t;
    import cpu_pkg::IDLE;
    import cpu_pkg::REQ;
    import cpu_pkg::DISCARD;

    localparam int c_CNT_W   = $clog2(DEPTH) + 1;
    localparam int c_ENTRY_W = 32 + INST_W;
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(DEPTH);
    localparam logic [31:0]        c_PC_STEP  = 32'd4;

    fetch_state_t r_state;
    fetch_state_t w_state_next;
    logic [31:0]  r_fetch_pc;
    logic [31:0]  w_fetch_pc_next;
    // Address of the abandoned read; the RAM still needs it held stable.
    logic [31:0]  r_stale_addr;
    logic [31:0]  w_stale_addr_next;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_empty;
    logic [c_CNT_W-1:0]   w_count;
    logic [c_CNT_W-1:0]   w_count_next;
    logic [c_ENTRY_W-1:0] w_head;
    logic [c_ENTRY_W-1:0] w_wr_entry;

    // Redirect wins over both queue operations; the flush clears the rest.
    assign w_push = (r_state == REQ) && bus.irom_fin && !bus.redirect;
    assign w_pop  = !w_empty && !bus.stall_if && !bus.redirect;

    assign w_count_next = w_count
                        + {{(c_CNT_W-1){1'b0}}, w_push}
                        - {{(c_CNT_W-1){1'b0}}, w_pop};

    // In REQ the fetch PC is still the address of the outstanding read.
    assign w_wr_entry = {r_fetch_pc, bus.ram_inst};

    sync_fifo_flush #(
        .WIDTH (c_ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (bus.redirect),
        .i_push    (w_push),
        .i_wr_data (w_wr_entry),
        .i_pop     (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_count),
        .o_empty   (w_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_fetch_pc   <= RESET_PC;
            r_stale_addr <= RESET_PC;
        end else begin
            r_state      <= w_state_next;
            r_fetch_pc   <= w_fetch_pc_next;
            r_stale_addr <= w_stale_addr_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_fetch_pc_next   = r_fetch_pc;
        w_stale_addr_next = r_stale_addr;
        case (r_state)
            IDLE: begin
                if (bus.redirect) begin
                    w_state_next    = REQ;
                    w_fetch_pc_next = bus.redirect_addr;
                end else if (w_count < c_CNT_FULL) begin
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (bus.redirect) begin
                    w_fetch_pc_next = bus.redirect_addr;
                    // A read that has not completed cannot be aborted; wait
                    // for its completion in DISCARD with the address held.
                    if (bus.irom_fin) begin
                        w_state_next = REQ;
                    end else begin
                        w_state_next      = DISCARD;
                        w_stale_addr_next = r_fetch_pc;
                    end
                end else if (bus.irom_fin) begin
                    w_fetch_pc_next = r_fetch_pc + c_PC_STEP;
                    w_state_next    = (w_count_next < c_CNT_FULL) ? REQ : IDLE;
                end
            end
            DISCARD: begin
                if (bus.redirect) begin
                    w_fetch_pc_next = bus.redirect_addr;
                end
                if (bus.irom_fin) begin
                    w_state_next = REQ;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign bus.iread_ce  = (r_state == REQ) || (r_state == DISCARD);
    assign bus.iram_addr = (r_state == DISCARD) ? r_stale_addr : r_fetch_pc;

    assign bus.inst_valid       = !w_empty;
    assign bus.inst             = w_empty ? NOP_INST : w_head[INST_W-1:0];
    assign bus.inst_address     = w_empty ? 32'd0 : w_head[c_ENTRY_W-1:INST_W];
    assign bus.next_instaddress = w_empty ? 32'd0 : (w_head[c_ENTRY_W-1:INST_W] + c_PC_STEP);
    assign bus.count            = w_count;

endmodule

`default_nettype wire

// File: tb/tb_inst_prefetch_queue.sv
//------------------------------------------------------------------------------
// Module  : tb_inst_prefetch_queue
// Purpose : Self-checking bench for inst_prefetch_queue. A behavioural RAM
//           answers requests after a programmable latency; every completed,
//           non-discarded read pushes its expected {pc, inst} to a scoreboard
//           that is popped whenever decode consumes the head. A second
//           instance (DEPTH=2, RESET_PC near the top of memory) covers the
//           address wrap.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_inst_prefetch_queue;

    localparam logic [31:0] c_NOP      = 32'h1357_9BDF;
    localparam logic [31:0] c_WRAP_PC  = 32'hFFFF_FFF8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    inst_prefetch_queue_if #(.DEPTH(4)) pq ();
    inst_prefetch_queue_if #(.DEPTH(2)) pw ();

    inst_prefetch_queue #(
        .DEPTH(4), .RESET_PC(32'h0000_0000), .NOP_INST(c_NOP)
    ) dut (
        .clk(clk), .rst(rst), .bus(pq)
    );

    inst_prefetch_queue #(
        .DEPTH(2), .RESET_PC(c_WRAP_PC), .NOP_INST(c_NOP)
    ) dut_wrap (
        .clk(clk), .rst(rst), .bus(pw)
    );

    int n_cmp = 0;
    int n_err = 0;

    // RAM model / scoreboard state
    int           lat;
    bit           busy;
    int           waited;
    logic [31:0]  req_addr;
    bit           stale;
    bit           force_dead;
    bit           dropped_fin;
    bit           w_stall;
    logic [31:0]  exp_pc;
    logic [63:0]  sb[$];
    logic [31:0]  wlog[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Called #1 after a rising edge: observe this cycle's outputs, drive this
    // cycle's inputs, then advance to #1 after the next edge.
    task automatic cycle(input bit stall, input bit redir, input logic [31:0] raddr);
        logic [63:0] e;
        logic [31:0] d;
        dropped_fin       = 1'b0;
        pq.stall_if       = stall;
        pq.redirect       = redir;
        pq.redirect_addr  = raddr;
        pq.irom_fin       = 1'b0;
        pq.ram_inst       = 32'h0;

        if (pq.inst_valid) begin
            check_eq("no_stale_data", 32'(pq.inst == 32'hDEADBEEF), 32'd0);
        end
        if (pq.inst_valid && !stall && !redir) begin
            check_eq("pop_has_expected", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("head_pc",   pq.inst_address,     e[63:32]);
                check_eq("head_inst", pq.inst,             e[31:0]);
                check_eq("next_pc",   pq.next_instaddress, e[63:32] + 32'd4);
            end
        end

        if (busy) begin
            check_eq("ce_held", 32'(pq.iread_ce), 32'd1);
        end
        if (pq.iread_ce) begin
            if (!busy) begin
                busy     = 1'b1;
                waited   = 0;
                req_addr = pq.iram_addr;
                check_eq("req_addr", pq.iram_addr, exp_pc);
            end else begin
                check_eq("addr_stable", pq.iram_addr, req_addr);
            end
            if (waited >= lat) begin
                d = force_dead ? 32'hDEADBEEF : mem_data(req_addr);
                pq.irom_fin = 1'b1;
                pq.ram_inst = d;
                busy        = 1'b0;
                force_dead  = 1'b0;
                if (stale || redir) begin
                    stale       = 1'b0;
                    dropped_fin = 1'b1;
                end else begin
                    sb.push_back({req_addr, d});
                    exp_pc = req_addr + 32'd4;
                end
            end else begin
                waited++;
            end
        end

        if (redir) begin
            sb.delete();
            exp_pc = raddr;
            if (busy) stale = 1'b1;
        end

        // Wrap instance: zero-latency RAM, stall under bench control.
        pw.stall_if      = w_stall;
        pw.redirect      = 1'b0;
        pw.redirect_addr = 32'h0;
        pw.irom_fin      = pw.iread_ce;
        pw.ram_inst      = mem_data(pw.iram_addr);
        if (pw.iread_ce) wlog.push_back(pw.iram_addr);

        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        pq.irom_fin = 1'b0;
        pq.redirect = 1'b0;
        pq.stall_if = 1'b1;
        pw.irom_fin = 1'b0;
        pw.redirect = 1'b0;
        pw.stall_if = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        busy   = 1'b0;
        stale  = 1'b0;
        force_dead = 1'b0;
        exp_pc = 32'h0;
        sb.delete();
        wlog.delete();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_iread_ce",   32'(pq.iread_ce),    32'd0);
        check_eq("rst_iram_addr",  pq.iram_addr,        32'h0);
        check_eq("rst_inst_valid", 32'(pq.inst_valid),  32'd0);
        check_eq("rst_inst",       pq.inst,             c_NOP);
        check_eq("rst_inst_addr",  pq.inst_address,     32'h0);
        check_eq("rst_next_addr",  pq.next_instaddress, 32'h0);
        check_eq("rst_count",      32'(pq.count),       32'd0);
        check_eq("rst_wrap_addr",  pw.iram_addr,        c_WRAP_PC);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit found;
        lat     = 0;
        w_stall = 1'b1;
        pq.redirect_addr = 32'h0;
        pq.ram_inst      = 32'h0;
        pw.redirect_addr = 32'h0;
        pw.ram_inst      = 32'h0;
        do_reset();
        check_reset_outputs();

        // Fill with decode stalled: 0x0, 0x4, 0x8, 0xC then stop.
        cycle(1'b1, 1'b0, 32'h0);
        check_eq("first_ce", 32'(pq.iread_ce), 32'd1);
        check_eq("no_bypass", 32'(pq.inst_valid), 32'd0);
        cycle(1'b1, 1'b0, 32'h0);
        check_eq("valid_after_fin", 32'(pq.inst_valid), 32'd1);
        check_eq("first_head_pc", pq.inst_address, 32'h0);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);
        check_eq("full_count", 32'(pq.count), 32'd4);
        check_eq("full_ce_low", 32'(pq.iread_ce), 32'd0);
        check_eq("full_next_pc", exp_pc, 32'h10);

        // Drain in order and stream onward from 0x10.
        repeat (14) cycle(1'b0, 1'b0, 32'h0);

        // Slow RAM, redirect while a read is in flight.
        lat = 4;
        cycle(1'b1, 1'b1, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (busy && req_addr == 32'h8) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1, 1'b0, 32'h0);
        end
        check_eq("wait_req8", 32'(found), 32'd1);
        force_dead = 1'b1;
        cycle(1'b1, 1'b1, 32'h100);
        check_eq("redir_valid_low", 32'(pq.inst_valid), 32'd0);
        check_eq("discard_addr", pq.iram_addr, 32'h8);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            if (dropped_fin) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("wait_stale_fin", 32'(found), 32'd1);
        check_eq("post_discard_ce",   32'(pq.iread_ce), 32'd1);
        check_eq("post_discard_addr", pq.iram_addr, 32'h100);
        repeat (12) cycle(1'b0, 1'b0, 32'h0);

        // Redirect coinciding with irom_fin.
        lat = 0;
        repeat (4) cycle(1'b0, 1'b0, 32'h0);
        check_eq("pre_same_ce", 32'(pq.iread_ce), 32'd1);
        cycle(1'b0, 1'b1, 32'h200);
        check_eq("same_fin_dropped", 32'(dropped_fin), 32'd1);
        check_eq("same_ce",    32'(pq.iread_ce), 32'd1);
        check_eq("same_addr",  pq.iram_addr, 32'h200);
        check_eq("same_valid", 32'(pq.inst_valid), 32'd0);
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // Reset while a read is outstanding and entries are queued.
        lat = 3;
        found = 1'b0;
        for (int i = 0; i < 80; i++) begin
            if (busy && pq.count == 3'd3) begin
                found = 1'b1;
                break;
            end
            cycle(1'b1, 1'b0, 32'h0);
        end
        check_eq("wait_busy_q3", 32'(found), 32'd1);
        do_reset();
        check_reset_outputs();
        lat = 0;
        cycle(1'b0, 1'b0, 32'h0);
        check_eq("refetch_ce",   32'(pq.iread_ce), 32'd1);
        check_eq("refetch_addr", pq.iram_addr, 32'h0);
        repeat (8) cycle(1'b0, 1'b0, 32'h0);

        // Wrap instance: filled during the cycles above with stall held.
        check_eq("wrap_count", 32'(pw.count), 32'd2);
        check_eq("wrap_ce_low", 32'(pw.iread_ce), 32'd0);
        check_eq("wrap_log_len", 32'(wlog.size()), 32'd2);
        if (wlog.size() >= 2) begin
            check_eq("wrap_req0", wlog[0], 32'hFFFF_FFF8);
            check_eq("wrap_req1", wlog[1], 32'hFFFF_FFFC);
        end
        check_eq("wrap_head0_pc",   pw.inst_address,     32'hFFFF_FFF8);
        check_eq("wrap_head0_next", pw.next_instaddress, 32'hFFFF_FFFC);
        check_eq("wrap_head0_inst", pw.inst,             mem_data(32'hFFFF_FFF8));
        w_stall = 1'b0;
        cycle(1'b1, 1'b0, 32'h0);
        w_stall = 1'b1;
        check_eq("wrap_head1_pc",   pw.inst_address,     32'hFFFF_FFFC);
        check_eq("wrap_head1_next", pw.next_instaddress, 32'h0);
        check_eq("wrap_head1_inst", pw.inst,             mem_data(32'hFFFF_FFFC));
        repeat (3) cycle(1'b1, 1'b0, 32'h0);
        check_eq("wrap_log_len3", 32'(wlog.size()), 32'd3);
        if (wlog.size() >= 3) begin
            check_eq("wrap_req2", wlog[2], 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
